// File: rtl/synth_pkg.sv
// Shared types and helpers for the audio synthesis datapath.
package synth_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic        [7:0]  amp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FINISH
  } mixer_state_t;

  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned AMP_W    = 8;
  localparam int unsigned PROD_W   = SAMPLE_W + AMP_W + 1;
  localparam int unsigned SAT_IN_W = 48;

  // Clamp a wide signed value into the 16-bit sample range.
  function automatic sample_t sat16(input logic signed [SAT_IN_W-1:0] v);
    sample_t r;
    if (v > SAT_IN_W'(SAMPLE_MAX)) begin
      r = 16'(SAMPLE_MAX);
    end else if (v < SAT_IN_W'(SAMPLE_MIN)) begin
      r = 16'(SAMPLE_MIN);
    end else begin
      r = v[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
module sample_tick_gen #(
  parameter int unsigned CLK_DIV = 2268
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered against the count it will accompany.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/partial_mixer.sv
// Polls a shared sine source once per partial each sample period, scales by a
// per-partial amplitude, accumulates and emits a saturated 16-bit mix.
module partial_mixer
  import synth_pkg::*;
#(
  parameter int unsigned NUM_PARTIALS = 8,
  parameter int unsigned CLK_DIV      = 2268,
  parameter int unsigned OUT_SHIFT    = 8,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            amp_wr_en,
  input  logic [$clog2(NUM_PARTIALS)-1:0] amp_wr_idx,
  input  logic [7:0]                      amp_wr_data,
  output logic                            sin_req,
  output logic [$clog2(NUM_PARTIALS)-1:0] sin_idx,
  input  logic signed [15:0]              sin_sample,
  input  logic                            sin_valid,
  output logic signed [15:0]              current_sample,
  output logic                            sample_valid,
  output logic                            busy,
  output logic                            err_overrun,
  output logic                            err_timeout
);

  localparam int unsigned IDX_W = $clog2(NUM_PARTIALS);
  localparam int unsigned ACC_W = PROD_W + IDX_W;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PARTIALS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  logic tick;

  sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  mixer_state_t              state_q, state_d;
  logic        [IDX_W-1:0]   idx_q, idx_d;
  logic        [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  amp_t                      amp_q [NUM_PARTIALS];
  amp_t                      amp_d [NUM_PARTIALS];
  sample_t                   cur_q, cur_d;
  logic                      sin_req_q, sin_req_d;
  logic                      sv_q, sv_d;
  logic                      busy_q, busy_d;
  logic                      ovr_q, ovr_d;
  logic                      tmo_q, tmo_d;

  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_sh;
  logic                      step;

  // Next-state, accumulation and registered-output computation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    to_cnt_d = to_cnt_q;
    acc_d    = acc_q;
    cur_d    = cur_q;
    tmo_d    = tmo_q;
    ovr_d    = ovr_q | (tick & (state_q != ST_IDLE));
    step     = 1'b0;
    amp_d    = amp_q;
    if (amp_wr_en) begin
      amp_d[amp_wr_idx] = amp_wr_data;
    end

    prod = PROD_W'(sin_sample) * PROD_W'($signed({1'b0, amp_q[idx_q]}));

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (sin_valid) begin
          acc_d = acc_q + ACC_W'(prod);
          step  = 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          tmo_d = 1'b1;
          step  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Either outcome of a partial advances to the next one or closes the frame.
    if (step) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_FINISH;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = ST_REQ;
      end
    end

    acc_sh = acc_d >>> OUT_SHIFT;
    if (state_d == ST_FINISH) begin
      cur_d = sat16(SAT_IN_W'(acc_sh));
    end

    sin_req_d = (state_d == ST_REQ);
    sv_d      = (state_d == ST_FINISH);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      to_cnt_q  <= '0;
      acc_q     <= '0;
      amp_q     <= '{default: '0};
      cur_q     <= '0;
      sin_req_q <= 1'b0;
      sv_q      <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      to_cnt_q  <= to_cnt_d;
      acc_q     <= acc_d;
      amp_q     <= amp_d;
      cur_q     <= cur_d;
      sin_req_q <= sin_req_d;
      sv_q      <= sv_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      tmo_q     <= tmo_d;
    end
  end

  assign sin_req        = sin_req_q;
  assign sin_idx        = idx_q;
  assign current_sample = cur_q;
  assign sample_valid   = sv_q;
  assign busy           = busy_q;
  assign err_overrun    = ovr_q;
  assign err_timeout    = tmo_q;

endmodule

// File: tb/tb_partial_mixer.sv
// Randomized bench for partial_mixer against a frame-schedule reference model.
module tb_partial_mixer;
  import synth_pkg::*;

  localparam int N       = 8;
  localparam int CLK_DIV = 128;
  localparam int TO      = 64;
  localparam int SH      = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        amp_wr_en;
  logic [2:0]  amp_wr_idx;
  logic [7:0]  amp_wr_data;
  logic        sin_req;
  logic [2:0]  sin_idx;
  sample_t     sin_sample;
  logic        sin_valid;
  sample_t     current_sample;
  logic        sample_valid;
  logic        busy;
  logic        err_overrun;
  logic        err_timeout;

  partial_mixer #(
    .NUM_PARTIALS (N),
    .CLK_DIV      (CLK_DIV),
    .OUT_SHIFT    (SH),
    .TIMEOUT      (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .amp_wr_en      (amp_wr_en),
    .amp_wr_idx     (amp_wr_idx),
    .amp_wr_data    (amp_wr_data),
    .sin_req        (sin_req),
    .sin_idx        (sin_idx),
    .sin_sample     (sin_sample),
    .sin_valid      (sin_valid),
    .current_sample (current_sample),
    .sample_valid   (sample_valid),
    .busy           (busy),
    .err_overrun    (err_overrun),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: amplitude table plus the schedule of the current frame.
  int     amp_m [N];
  bit     in_frame;
  int     t0, fin;
  int     req_c [N];
  int     acc_c [N];
  bit     dead  [N];
  int     smp   [N];
  longint sum_m;
  int     cur_m;
  bit     ovr_m, tmo_m, ovr_pend, tmo_pend;

  // Stimulus knobs.
  int lat_min = 1, lat_max = 1, dead_idx = -1, smp_mode = 1, smp_const = 32767;
  bit rand_wr = 0, junk_en = 0, dead_rand = 0;
  int wq_idx [$];
  int wq_dat [$];

  function automatic int sat_m(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) amp_m[i] = 0;
    in_frame = 0; t0 = 0; fin = 0; sum_m = 0; cur_m = 0;
    ovr_m = 0; tmo_m = 0; ovr_pend = 0; tmo_pend = 0;
  endtask

  task automatic start_frame();
    int r, lat, force_lat;
    sample_t tmp16;
    force_lat = (dead_rand && $urandom_range(5) == 0) ? 15 : 0;
    if (dead_rand) dead_idx = ($urandom_range(3) == 0) ? int'($urandom_range(N - 1)) : -1;
    t0 = cyc; in_frame = 1; sum_m = 0; r = cyc + 1;
    for (int i = 0; i < N; i++) begin
      dead[i] = (i == dead_idx);
      lat = (force_lat != 0) ? force_lat : lat_min + int'($urandom_range(lat_max - lat_min));
      if (dead[i]) lat = TO;
      tmp16 = 16'($urandom);
      case (smp_mode)
        0:       smp[i] = int'(tmp16);
        2:       smp[i] = (i == 0) ? 16384 : int'(tmp16);
        default: smp[i] = smp_const;
      endcase
      req_c[i] = r;
      acc_c[i] = r + lat;
      r = acc_c[i] + 1;
    end
    fin = r;
  endtask

  // Expected outputs for the current cycle, checked every cycle.
  task automatic compare();
    int exp_idx;
    bit exp_req, exp_sv, exp_busy;
    exp_req  = 0;
    exp_idx  = -1;
    exp_busy = in_frame && (cyc > t0);
    exp_sv   = in_frame && (cyc == fin);
    if (in_frame) begin
      for (int i = 0; i < N; i++) begin
        if (cyc == req_c[i]) exp_req = 1;
        if (cyc >= req_c[i] && cyc <= acc_c[i]) exp_idx = i;
      end
    end
    if (exp_sv) cur_m = sat_m(sum_m >>> SH);
    check("sin_req", longint'(sin_req), longint'(exp_req));
    if (exp_idx >= 0) check("sin_idx", longint'(sin_idx), longint'(exp_idx));
    check("sample_valid", longint'(sample_valid), longint'(exp_sv));
    check("busy", longint'(busy), longint'(exp_busy));
    check("current_sample", longint'(current_sample), longint'(cur_m));
    check("err_overrun", longint'(err_overrun), longint'(ovr_m));
    check("err_timeout", longint'(err_timeout), longint'(tmo_m));
  endtask

  task automatic drive();
    bit junk_ok;
    sin_valid   = 1'b0;
    sin_sample  = 16'($urandom);
    amp_wr_en   = 1'b0;
    amp_wr_idx  = 3'($urandom);
    amp_wr_data = 8'($urandom);
    if (in_frame) begin
      for (int i = 0; i < N; i++) begin
        if (cyc == acc_c[i] && !dead[i]) begin
          sin_valid  = 1'b1;
          sin_sample = 16'(smp[i]);
          sum_m += longint'(smp[i]) * longint'(amp_m[i]);
        end
      end
    end
    // Spurious valids only where the mixer must ignore them.
    if (!sin_valid && junk_en && $urandom_range(3) == 0) begin
      junk_ok = !in_frame || cyc == t0 || cyc == fin;
      if (in_frame) for (int i = 0; i < N; i++) if (cyc == req_c[i]) junk_ok = 1;
      sin_valid = junk_ok;
    end
    if (wq_idx.size() > 0) begin
      amp_wr_en   = 1'b1;
      amp_wr_idx  = 3'(wq_idx.pop_front());
      amp_wr_data = 8'(wq_dat.pop_front());
    end else if (rand_wr && $urandom_range(7) == 0) begin
      amp_wr_en = 1'b1;
    end
    if (amp_wr_en) amp_m[int'(amp_wr_idx)] = int'(amp_wr_data);
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (ovr_pend) ovr_m = 1;
    if (tmo_pend) tmo_m = 1;
    ovr_pend = 0;
    tmo_pend = 0;
    if (in_frame && cyc > fin) in_frame = 0;
    if ((cyc % CLK_DIV) == 0) begin
      if (in_frame) ovr_pend = 1;
      else start_frame();
    end
    if (in_frame) for (int i = 0; i < N; i++) if (dead[i] && cyc == acc_c[i]) tmo_pend = 1;
    compare();
    drive();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; amp_wr_en = 1'b0; sin_valid = 1'b0; sin_sample = '0;
    amp_wr_idx = '0; amp_wr_data = '0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;
    model_reset();
    check("rst_sin_idx", longint'(sin_idx), 0);
    compare();
    drive();
  endtask

  task automatic wait_sv(input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      run_cycle();
      if (sample_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      tests++;
      fails++;
      $display("FAIL wait_sample_valid actual=none required=pulse within %0d cycles", bound);
    end
  endtask

  task automatic queue_wr(input int idx, input int dat);
    wq_idx.push_back(idx);
    wq_dat.push_back(dat);
  endtask

  int at, at2, k;

  initial begin
    do_reset(3);

    // All amplitudes zero, latency 1.
    wait_sv(400, at);
    check("first_sv_cycle", at, CLK_DIV + 17);
    check("zero_amp_out", longint'(current_sample), 0);
    check("zero_amp_tmo", longint'(err_timeout), 0);
    check("zero_amp_ovr", longint'(err_overrun), 0);

    // Single partial.
    queue_wr(0, 255);
    smp_mode = 2;
    wait_sv(400, at);
    check("single_255", longint'(current_sample), 16320);
    queue_wr(0, 128);
    wait_sv(400, at);
    check("single_128", longint'(current_sample), 8192);

    // Saturation both ways.
    for (int i = 0; i < N; i++) queue_wr(i, 255);
    smp_mode = 1; smp_const = 32767;
    wait_sv(400, at);
    check("sat_pos", longint'(current_sample), 32767);
    smp_const = -32768;
    wait_sv(400, at);
    check("sat_neg", longint'(current_sample), -32768);

    // Partial 3 never answers.
    smp_const = 1000; dead_idx = 3;
    wait_sv(400, at);
    check("timeout_out", longint'(current_sample), 6972);
    check("timeout_flag", longint'(err_timeout), 1);
    check("timeout_frame_len", at % CLK_DIV, 80);
    dead_idx = -1;

    // 129-cycle frames against a 128-cycle tick period.
    lat_min = 15; lat_max = 15;
    wait_sv(400, at);
    check("overrun_out", longint'(current_sample), 7968);
    check("overrun_flag", longint'(err_overrun), 1);
    wait_sv(400, at2);
    check("overrun_sv_spacing", at2 - at, 2 * CLK_DIV);

    // Reset while waiting on partial 4.
    lat_min = 3; lat_max = 3;
    k = 0;
    while (!(in_frame && cyc == req_c[4] + 1) && k < 600) begin
      run_cycle();
      k++;
    end
    check("midrst_idx", longint'(sin_idx), 4);
    check("midrst_busy", longint'(busy), 1);
    do_reset(2);
    wait_sv(400, at);
    check("post_rst_sv_cycle", at, CLK_DIV + 33);
    check("post_rst_out", longint'(current_sample), 0);

    // Randomized traffic.
    lat_min = 1; lat_max = 4; smp_mode = 0;
    rand_wr = 1; junk_en = 1; dead_rand = 1;
    for (int i = 0; i < N; i++) queue_wr(i, int'($urandom_range(255)));
    repeat (4000) run_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
